// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   WIDTH_DEF : default operand width
//   op_t      : op field encoding (6/7 are no-ops)
//   state_t   : sequencer states
package muldiv_seq_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

endpackage

// File: rtl/muldiv_seq_udiv_core.sv
// Iterative unsigned restoring divider, one quotient bit per step, MSB first.
//   clk, reset          : clock, synchronous active-high reset
//   load                : capture dividend/divisor and clear the partial remainder
//   step                : perform one restoring iteration
//   dividend, divisor   : operands (divisor must be non-zero)
//   quotient, remainder : results, valid after WIDTH steps
module udiv_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] d;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   r_trial;
  logic             fits;

  // The quotient register doubles as the dividend shift register.
  always_comb begin
    r_shift = {r, q[WIDTH-1]};
    r_trial = r_shift - {1'b0, d};
    fits    = (r_shift >= {1'b0, d});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
      r <= '0;
      d <= '0;
    end else if (load) begin
      q <= dividend;
      r <= '0;
      d <= divisor;
    end else if (step) begin
      q <= {q[WIDTH-2:0], fits};
      r <= fits ? r_trial[WIDTH-1:0] : r_shift[WIDTH-1:0];
    end
  end

  assign quotient  = q;
  assign remainder = r;

endmodule

// File: rtl/muldiv_seq.sv
// Multiply/divide sequencer owning HI/LO. Signed ops are done on magnitudes
// with a shared unsigned multiplier and iterative divider; signs fixed at write.
//   clk, reset     : clock, synchronous active-high reset
//   start, op      : request and operation code (sampled only when idle)
//   rs_val, rt_val : operands
//   busy           : operation in flight, pipeline must stall
//   done           : one-cycle pulse after a mul/div wrote HI/LO
//   hi, lo         : HI/LO registers
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX) + 1;

  state_t           state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             neg, qneg, rneg, dz;

  logic             is_mul, is_div, signed_op, rt_zero;
  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quot, rem;
  logic             div_load, div_step, mul_wr, fix_wr;

  // Operand decode and sign/magnitude conversion.
  always_comb begin
    is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    is_div    = (op == OP_DIV)  || (op == OP_DIVU);
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    rt_zero   = (rt_val == '0);
    rs_neg    = signed_op & rs_val[WIDTH-1];
    rt_neg    = signed_op & rt_val[WIDTH-1];
    rs_mag    = rs_neg ? -rs_val : rs_val;
    rt_mag    = rt_neg ? -rt_val : rt_val;
  end

  // Shared unsigned multiplier, fed from the magnitude registers.
  assign prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};

  udiv_core #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (div_load),
    .step      (div_step),
    .dividend  (rs_mag),
    .divisor   (rt_mag),
    .quotient  (quot),
    .remainder (rem)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start && is_mul)      state_next = S_MUL;
        else if (start && is_div) state_next = rt_zero ? S_FIX : S_DIV;
      end
      S_MUL:   if (count == '0) state_next = S_IDLE;
      S_DIV:   if (count == '0) state_next = S_FIX;
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Control outputs
  always_comb begin
    busy     = (state != S_IDLE);
    div_load = (state == S_IDLE) && start && is_div && !rt_zero;
    div_step = (state == S_DIV);
    mul_wr   = (state == S_MUL) && (count == '0);
    fix_wr   = (state == S_FIX);
  end

  // Datapath registers. Divide-by-zero parks the raw dividend in mag_a
  // and goes straight to FIX, which then writes it to HI.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
      count <= '0;
      mag_a <= '0;
      mag_b <= '0;
      neg   <= 1'b0;
      qneg  <= 1'b0;
      rneg  <= 1'b0;
      dz    <= 1'b0;
    end else begin
      done <= mul_wr | fix_wr;
      case (state)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MTHI: hi <= rs_val;
              OP_MTLO: lo <= rs_val;
              OP_MULT, OP_MULTU: begin
                mag_a <= rs_mag;
                mag_b <= rt_mag;
                neg   <= rs_neg ^ rt_neg;
                count <= CW'(MUL_CYCLES - 1);
              end
              OP_DIV, OP_DIVU: begin
                if (rt_zero) begin
                  mag_a <= rs_val;
                  dz    <= 1'b1;
                end else begin
                  qneg  <= rs_neg ^ rt_neg;
                  rneg  <= rs_neg;
                  dz    <= 1'b0;
                  count <= CW'(WIDTH - 1);
                end
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (count == '0) {hi, lo} <= neg ? -prod : prod;
          else             count    <= count - CW'(1);
        end
        S_DIV: begin
          if (count != '0) count <= count - CW'(1);
        end
        S_FIX: begin
          if (dz) begin
            hi <= mag_a;
            lo <= '1;
          end else begin
            lo <= qneg ? -quot : quot;
            hi <= rneg ? -rem  : rem;
          end
          dz <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multiply/divide sequencer owning the HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO. Sits beside the ALU in the CPU execute path. It shares one 32x32 unsigned combinational multiplier and one iterative unsigned divider between signed and unsigned operations, using sign/magnitude conversion. It raises `busy` so the CPU control stalls the pipeline while an operation runs.

## Interface
- `WIDTH`, 32, operand width; HI/LO are each `WIDTH` bits.
- `MUL_CYCLES`, 4, cycles operands are held stable on the multiplier before the product is captured (≥1).
- `clk` in 1 — clock; all state changes on rising edge.
- `reset` in 1 — synchronous, active-high.
- `start` in 1 — request; sampled only when `busy`=0.
- `op` in 3 — 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op.
- `rs_val` in WIDTH — multiplicand / dividend / MTHI/MTLO source.
- `rt_val` in WIDTH — multiplier / divisor.
- `busy` out 1 — operation in flight; CPU must stall.
- `done` out 1 — one-cycle pulse after HI/LO written by a mul/div.
- `hi` out WIDTH — HI register.
- `lo` out WIDTH — LO register.

## Operation
- Reset: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, counters 0; reset mid-operation aborts with no HI/LO write.
- States: IDLE, MUL, DIV, FIX.
- IDLE, `start` with op 4/5: `hi` (resp. `lo`) ← `rs_val` at that edge; no `busy`, no `done`.
- IDLE, `start` with op 0/1: latch magnitudes `|rs|`,`|rt|` (signed ops only; unsigned pass raw), `neg`=sign(rs)^sign(rt) for MULT else 0, count ← MUL_CYCLES-1, → MUL.
- MUL: count decrements; at count 0 → `{hi,lo}` ← product (2's-complement negated over 2·WIDTH if `neg`), `done`, → IDLE.
- IDLE, `start` with op 2/3, `rt_val`≠0: latch magnitudes, `qneg`=sign(rs)^sign(rt), `rneg`=sign(rs) (signed only), count ← WIDTH-1, → DIV.
- DIV: one restoring step per cycle, quotient bit MSB first; at count 0 → FIX.
- FIX: `lo` ← quotient (negated if `qneg`), `hi` ← remainder (negated if `rneg`), `done`, → IDLE.
- Divide by zero (op 2/3, `rt_val`=0): no iteration; next edge `hi` ← `rs_val`, `lo` ← all ones, `done`.
- DIV 0x80000000 / 0xFFFFFFFF: natural magnitude result, `lo`=0x80000000, `hi`=0.
- `start` while `busy`=1: ignored, no effect.
- `op` 6/7: no effect.

## Timing
- Accept edge E0.
- MUL: `busy`=1 from after E0 until edge E_MUL_CYCLES, which writes HI/LO; `busy`=0 and `done`=1 for the following cycle.
- DIV: iterations E1..E_WIDTH; FIX write at E_WIDTH+1; `busy` high WIDTH+1 cycles, then `done` 1 cycle.
- Divide by zero: write at E1, `busy` high 1 cycle.
- New `start` accepted in the same cycle `done`=1 (back-to-back allowed).
- HI/LO readers see the new value the cycle `done` is high; old value held throughout `busy`.

## Structure
- Shared package: op encoding constants (MULT..MTLO), state encoding, `WIDTH` default.
- Sub-module `udiv_core`: iterative unsigned restoring divider (load, step, quotient/remainder out).
- Product comes from the team's existing 32x32 unsigned combinational multiplier, fed from the magnitude registers. The sequencer owns all sign handling.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, MUL_CYCLES=4 -> `busy` exactly 4 cycles; then `hi`=0xFFFFFFFE, `lo`=0x00000001, `done` 1 cycle.
- MULT 0xFFFFFFFD (−3) × 5 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. MULT −3 × −5 -> `hi`=0, `lo`=15.
- DIV −7 / 2 -> `busy` 33 cycles; `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 100 / 7 -> `lo`=14, `hi`=2.
- DIVU 0x64 / 0 -> 1 cycle later `hi`=0x64, `lo`=0xFFFFFFFF, `done`. DIV 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- MTHI 0x1234 then MTLO 0x5678 -> `hi`=0x1234, `lo`=0x5678, `busy`/`done` never asserted. `start` during DIV busy -> ignored, DIV result unaffected.
- `reset` at DIV iteration 10 -> next cycle `busy`=0, `done`=0, `hi`=`lo`=0. A following MULTU 2×3 completes normally with `lo`=6.
